// File: rtl/altera_tse_lock_monitor_pkg.sv
// Shared types and helpers for the transceiver link lock monitor.
package altera_tse_lock_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INIT_RST   = 3'd1,
    ST_WAIT_RDY   = 3'd2,
    ST_MONITOR    = 3'd3,
    ST_RX_RST     = 3'd4,
    ST_WAIT_RXRDY = 3'd5,
    ST_FAILED     = 3'd6
  } state_e;

  // Cycles the sequencer needs to deassert rx_ready after reset_rx_digital.
  localparam int unsigned RX_IGNORE_CYCLES = 32'd4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/altera_tse_lock_filter.sv
// Two-flop synchronizer followed by a saturating counter of consecutive low samples.
module altera_tse_lock_filter #(
  parameter int unsigned lock_filter_cycles = 8
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic lock_i,
  output logic lost_o
);

  localparam int unsigned CW = $clog2(lock_filter_cycles + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(lock_filter_cycles);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= lock_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  assign lost_o = (cnt_q == CNT_SAT);

endmodule

// File: rtl/altera_tse_xcvr_lock_monitor.sv
// Link supervisor ahead of the transceiver reset sequencer: filters lock status,
// issues full / RX-digital resets, times out and retries, and latches a sticky failure.
module altera_tse_xcvr_lock_monitor
  import altera_tse_lock_monitor_pkg::*;
#(
  parameter int unsigned sys_clk_in_mhz     = 50,
  parameter int unsigned ready_timeout_us   = 1000,
  parameter int unsigned lock_filter_cycles = 8,
  parameter int unsigned reset_pulse_cycles = 4,
  parameter int unsigned max_retries        = 7,
  parameter int unsigned rx_digital_first   = 1,
  localparam int unsigned RW = $clog2(max_retries + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          pll_is_locked,
  input  logic          rx_is_lockedtodata,
  input  logic          tx_ready,
  input  logic          rx_ready,
  input  logic          clear_fail,
  output logic          seq_reset_all,
  output logic          seq_reset_rx_digital,
  output logic          link_up,
  output logic          link_fail,
  output logic [RW-1:0] retry_count,
  output logic [2:0]    state_dbg
);

  localparam int unsigned TIMEOUT_CYCLES = sys_clk_in_mhz * ready_timeout_us;
  localparam int unsigned TIMER_MAX =
    max_u(max_u(TIMEOUT_CYCLES, reset_pulse_cycles), RX_IGNORE_CYCLES);
  localparam int unsigned TW = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LAST   = TW'(reset_pulse_cycles - 1);
  localparam logic [TW-1:0] RX_IGNORE    = TW'(RX_IGNORE_CYCLES);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(max_retries - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(max_retries);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          fail_q, fail_d;
  logic          rst_all_q, rst_rxd_q, up_q;
  logic          pll_lost, rx_lost;
  logic          pulse_done, timed_out;
  logic [RW-1:0] retry_inc;
  state_e        timeout_state;

  altera_tse_lock_filter #(.lock_filter_cycles(lock_filter_cycles)) u_pll_filter (
    .clock_i (clock),
    .reset_i (reset),
    .lock_i  (pll_is_locked),
    .lost_o  (pll_lost)
  );

  altera_tse_lock_filter #(.lock_filter_cycles(lock_filter_cycles)) u_rx_filter (
    .clock_i (clock),
    .reset_i (reset),
    .lock_i  (rx_is_lockedtodata),
    .lost_o  (rx_lost)
  );

  assign pulse_done    = (timer_q == PULSE_LAST);
  assign timed_out     = (timer_q == TIMEOUT_LAST);
  // Saturate so a re-enable after FAILED cannot wrap the count back to zero.
  assign retry_inc     = (retry_q >= RETRY_MAX) ? retry_q : retry_q + 1'b1;
  assign timeout_state = (retry_q >= RETRY_LAST) ? ST_FAILED : ST_INIT_RST;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_INIT_RST;
        ST_INIT_RST: state_d = pulse_done ? ST_WAIT_RDY : ST_INIT_RST;
        ST_WAIT_RDY: begin
          if (tx_ready && rx_ready) begin
            state_d = ST_MONITOR;
            retry_d = '0;
          end else if (timed_out) begin
            state_d = timeout_state;
            retry_d = retry_inc;
          end else begin
            state_d = ST_WAIT_RDY;
          end
        end
        ST_MONITOR: begin
          if (pll_lost || !tx_ready || !rx_ready) begin
            state_d = ST_INIT_RST;
          end else if (rx_lost) begin
            state_d = (rx_digital_first != 0) ? ST_RX_RST : ST_INIT_RST;
          end else begin
            state_d = ST_MONITOR;
          end
        end
        ST_RX_RST:   state_d = pulse_done ? ST_WAIT_RXRDY : ST_RX_RST;
        ST_WAIT_RXRDY: begin
          if ((timer_q >= RX_IGNORE) && rx_ready && !rx_lost) begin
            state_d = ST_MONITOR;
          end else if (timed_out) begin
            state_d = timeout_state;
            retry_d = retry_inc;
          end else begin
            state_d = ST_WAIT_RXRDY;
          end
        end
        ST_FAILED: begin
          if (clear_fail) begin
            state_d = ST_INIT_RST;
            retry_d = '0;
          end else begin
            state_d = ST_FAILED;
          end
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fail_d  = fail_q;
    timer_d = timer_q;
    if ((state_q == ST_FAILED) && (state_d == ST_INIT_RST)) begin
      fail_d = 1'b0;
    end else if (state_d == ST_FAILED) begin
      fail_d = 1'b1;
    end else begin
      fail_d = fail_q;
    end
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (&timer_q) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      fail_q    <= 1'b0;
      rst_all_q <= 1'b0;
      rst_rxd_q <= 1'b0;
      up_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      fail_q    <= fail_d;
      rst_all_q <= (state_d == ST_INIT_RST);
      rst_rxd_q <= (state_d == ST_RX_RST);
      up_q      <= (state_d == ST_MONITOR);
    end
  end

  assign seq_reset_all        = rst_all_q;
  assign seq_reset_rx_digital = rst_rxd_q;
  assign link_up              = up_q;
  assign link_fail            = fail_q;
  assign retry_count          = retry_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_altera_tse_xcvr_lock_monitor.sv
// Bench for altera_tse_xcvr_lock_monitor: directed vector table, corner sequences, random vs. model.
module tb_altera_tse_xcvr_lock_monitor;

  localparam int MHZ = 1, TUS = 20, LFC = 4, RPC = 4, MAXR = 3, RXF = 1;
  localparam int T = MHZ * TUS;
  localparam int PH_IDLE = 0, PH_FULL = 1, PH_WAIT = 2, PH_MON = 3, PH_RXD = 4, PH_WAITRX = 5, PH_FAIL = 6;

  logic clock = 1'b0;
  logic rst = 1'b1, enable = 1'b0, pll_lock = 1'b1, rx_lock = 1'b1;
  logic tx_rdy = 1'b0, rx_rdy = 1'b0, clr_fail = 1'b0;
  logic seq_reset_all, seq_reset_rx_digital, link_up, link_fail;
  logic [1:0] retry_count;
  logic [2:0] state_dbg;
  logic [8:0] dut_vec;

  altera_tse_xcvr_lock_monitor #(
    .sys_clk_in_mhz(MHZ), .ready_timeout_us(TUS), .lock_filter_cycles(LFC),
    .reset_pulse_cycles(RPC), .max_retries(MAXR), .rx_digital_first(RXF)
  ) dut (
    .clock(clock), .reset(rst), .enable(enable), .pll_is_locked(pll_lock),
    .rx_is_lockedtodata(rx_lock), .tx_ready(tx_rdy), .rx_ready(rx_rdy), .clear_fail(clr_fail),
    .seq_reset_all(seq_reset_all), .seq_reset_rx_digital(seq_reset_rx_digital),
    .link_up(link_up), .link_fail(link_fail), .retry_count(retry_count), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  assign dut_vec = {seq_reset_all, seq_reset_rx_digital, link_up, link_fail, retry_count, state_dbg};

  int checks = 0;
  int failures = 0;

  // Reference model: phase, cycles spent in phase, and raw lock sample history (bit 0 newest).
  int m_phase = PH_IDLE, m_age = 0, m_retry = 0;
  bit m_fail = 1'b0;
  logic [7:0] pll_h = 8'hFC, rx_h = 8'hFC;

  task automatic on_timeout(output int nxt);
    bit give_up;
    give_up = (m_retry + 1 >= MAXR);
    m_retry = (m_retry < MAXR) ? m_retry + 1 : MAXR;
    if (give_up) begin
      m_fail = 1'b1;
      nxt = PH_FAIL;
    end else begin
      nxt = PH_FULL;
    end
  endtask

  task automatic model_step();
    bit pl, rl;
    int nxt;
    if (rst) begin
      m_phase = PH_IDLE; m_age = 0; m_retry = 0; m_fail = 1'b0;
      pll_h = 8'hFC; rx_h = 8'hFC;
      return;
    end
    // Lost once LFC consecutive samples, seen two cycles late, were all low.
    pl = (pll_h[LFC+1:2] == '0);
    rl = (rx_h[LFC+1:2] == '0);
    nxt = m_phase;
    if (!enable) nxt = PH_IDLE;
    else case (m_phase)
      PH_IDLE:   nxt = PH_FULL;
      PH_FULL:   if (m_age == RPC - 1) nxt = PH_WAIT;
      PH_WAIT:   if (tx_rdy && rx_rdy) begin nxt = PH_MON; m_retry = 0; end
                 else if (m_age == T - 1) on_timeout(nxt);
      PH_MON:    if (pl || !tx_rdy || !rx_rdy) nxt = PH_FULL;
                 else if (rl) nxt = (RXF != 0) ? PH_RXD : PH_FULL;
      PH_RXD:    if (m_age == RPC - 1) nxt = PH_WAITRX;
      PH_WAITRX: if (m_age >= 4 && rx_rdy && !rl) nxt = PH_MON;
                 else if (m_age == T - 1) on_timeout(nxt);
      PH_FAIL:   if (clr_fail) begin nxt = PH_FULL; m_retry = 0; m_fail = 1'b0; end
      default:   nxt = PH_IDLE;
    endcase
    m_age = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt;
    pll_h = {pll_h[6:0], pll_lock};
    rx_h = {rx_h[6:0], rx_lock};
  endtask

  function automatic logic [8:0] model_vec();
    return {m_phase == PH_FULL, m_phase == PH_RXD, m_phase == PH_MON, m_fail, 2'(m_retry), 3'(m_phase)};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {all,rxd,up,fail,retry,state} got %b want %b", name, act, exp);
    end
  endtask

  typedef struct {
    int n;
    bit en, pll, rxl, txr, rxr, clr;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int n, input bit en, pll, rxl, txr, rxr, clr,
                              input bit a, d, u, f, input int r, input int s);
    vec_t v;
    v.n = n; v.en = en; v.pll = pll; v.rxl = rxl; v.txr = txr; v.rxr = rxr; v.clr = clr;
    v.exp = {a, d, u, f, 2'(r), 3'(s)};
    tbl.push_back(v);
  endfunction

  initial begin
    bit found;
    int pll_low = 0, rx_low = 0, en_off = 0, tx_dly = 0, rx_dly = 0;

    //  n   en pll rxl txr rxr clr  all rxd up fail retry state
    add(4,  1, 1,  1,  0,  0,  0,   1,  0,  0, 0,   0,    1);  // power-up full reset pulse
    add(10, 1, 1,  1,  0,  0,  0,   0,  0,  0, 0,   0,    2);
    add(1,  1, 1,  1,  1,  1,  0,   0,  0,  1, 0,   0,    3);
    add(3,  1, 1,  0,  1,  1,  0,   0,  0,  1, 0,   0,    3);  // short rx glitch filtered
    add(6,  1, 1,  1,  1,  1,  0,   0,  0,  1, 0,   0,    3);
    add(6,  1, 1,  0,  1,  1,  0,   0,  0,  1, 0,   0,    3);  // real rx loss
    add(1,  1, 1,  1,  1,  1,  0,   0,  1,  0, 0,   0,    4);
    add(3,  1, 1,  1,  1,  0,  0,   0,  1,  0, 0,   0,    4);
    add(5,  1, 1,  1,  1,  1,  0,   0,  0,  0, 0,   0,    5);  // rx_ready ignored early
    add(1,  1, 1,  1,  1,  1,  0,   0,  0,  1, 0,   0,    3);
    add(4,  1, 1,  1,  1,  1,  0,   0,  0,  1, 0,   0,    3);
    add(6,  1, 0,  0,  1,  1,  0,   0,  0,  1, 0,   0,    3);  // pll+rx loss: full reset wins
    add(1,  1, 0,  0,  1,  1,  0,   1,  0,  0, 0,   0,    1);
    add(3,  1, 0,  0,  0,  0,  0,   1,  0,  0, 0,   0,    1);
    add(3,  1, 0,  0,  0,  0,  0,   0,  0,  0, 0,   0,    2);  // losses ignored while waiting
    add(6,  1, 1,  1,  0,  0,  0,   0,  0,  0, 0,   0,    2);
    add(1,  1, 1,  1,  1,  1,  0,   0,  0,  1, 0,   0,    3);
    add(4,  1, 1,  1,  0,  0,  0,   1,  0,  0, 0,   0,    1);  // readies never return
    add(20, 1, 1,  1,  0,  0,  0,   0,  0,  0, 0,   0,    2);
    add(4,  1, 1,  1,  0,  0,  0,   1,  0,  0, 0,   1,    1);
    add(20, 1, 1,  1,  0,  0,  0,   0,  0,  0, 0,   1,    2);
    add(4,  1, 1,  1,  0,  0,  0,   1,  0,  0, 0,   2,    1);
    add(20, 1, 1,  1,  0,  0,  0,   0,  0,  0, 0,   2,    2);
    add(30, 1, 1,  1,  0,  0,  0,   0,  0,  0, 1,   3,    6);
    add(1,  1, 1,  1,  0,  0,  1,   1,  0,  0, 0,   0,    1);  // clear_fail restarts
    add(1,  1, 1,  1,  0,  0,  0,   1,  0,  0, 0,   0,    1);
    add(1,  0, 1,  1,  0,  0,  0,   0,  0,  0, 0,   0,    0);  // enable drop truncates pulse
    add(3,  0, 1,  1,  0,  0,  0,   0,  0,  0, 0,   0,    0);
    add(4,  1, 1,  1,  0,  0,  0,   1,  0,  0, 0,   0,    1);
    add(2,  1, 1,  1,  0,  0,  0,   0,  0,  0, 0,   0,    2);
    add(1,  1, 1,  1,  1,  1,  0,   0,  0,  1, 0,   0,    3);
    add(6,  1, 1,  0,  1,  1,  0,   0,  0,  1, 0,   0,    3);
    add(1,  1, 1,  1,  1,  1,  0,   0,  1,  0, 0,   0,    4);
    add(3,  1, 1,  1,  1,  0,  0,   0,  1,  0, 0,   0,    4);
    add(20, 1, 1,  1,  1,  0,  0,   0,  0,  0, 0,   0,    5);  // rx never ready: escalate
    add(4,  1, 1,  1,  0,  0,  0,   1,  0,  0, 0,   1,    1);
    add(4,  1, 1,  1,  0,  0,  0,   0,  0,  0, 0,   1,    2);

    rst = 1'b1;
    repeat (3) cycle();
    check("reset_state", dut_vec, 9'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en; pll_lock = tbl[i].pll; rx_lock = tbl[i].rxl;
      tx_rdy = tbl[i].txr; rx_rdy = tbl[i].rxr; clr_fail = tbl[i].clr;
      for (int c = 0; c < tbl[i].n; c++) begin
        cycle();
        check($sformatf("vec%0d.cyc%0d", i, c), dut_vec, tbl[i].exp);
      end
    end

    // Reset asserted while waiting for rx_ready after an RX-digital reset.
    tx_rdy = 1'b1; rx_rdy = 1'b1;
    cycle();
    check("ready_clears_retry", dut_vec, {3'b001, 1'b0, 2'd0, 3'd3});
    rx_lock = 1'b0;
    repeat (6) cycle();
    rx_lock = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      cycle();
      if (state_dbg == 3'd4) rx_rdy = 1'b0;
      if (state_dbg == 3'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_wait_rxrdy: state_dbg=%0d after 30 cycles, want 5", state_dbg);
    end
    rst = 1'b1;
    cycle();
    check("reset_in_wait_rxrdy", dut_vec, 9'd0);
    rst = 1'b0;

    // Random traffic with a loosely modelled sequencer, checked against the reference model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 699) == 0);
      if (pll_low > 0) pll_low--;
      else if ($urandom_range(0, 59) == 0) pll_low = $urandom_range(1, 8);
      pll_lock = (pll_low == 0);
      if (rx_low > 0) rx_low--;
      else if ($urandom_range(0, 39) == 0) rx_low = $urandom_range(1, 8);
      rx_lock = (rx_low == 0);
      if (en_off > 0) en_off--;
      else if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 5);
      enable = (en_off == 0);
      clr_fail = ($urandom_range(0, 29) == 0);
      if (seq_reset_all) begin
        tx_dly = $urandom_range(2, 26);
        rx_dly = tx_dly + $urandom_range(0, 3);
      end else if (seq_reset_rx_digital) begin
        rx_dly = $urandom_range(2, 12);
      end else begin
        if (tx_dly > 0) tx_dly--;
        if (rx_dly > 0) rx_dly--;
      end
      tx_rdy = (tx_dly == 0) && ($urandom_range(0, 149) != 0);
      rx_rdy = (rx_dly == 0) && ($urandom_range(0, 149) != 0);
      cycle();
      check($sformatf("rand%0d", i), dut_vec, model_vec());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
